// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: bundles the EX/MEM request handshake, the data-bank bus and the
// MEM/WB result lines of the MEM-stage load/store unit.
//   master : pipeline + bank side (drives requests and bank read data)
//   slave  : the load/store unit (accepts requests, drives bank strobes and results)
interface mem_stage_lsu_if;
  // EX/MEM request
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  // Data memory bank
  logic        dm_memread;
  logic        dm_memwrite;
  logic [31:0] dm_address;
  logic [31:0] dm_writedata;
  logic [31:0] dm_readdata;
  // MEM/WB result
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_regwrite;
  logic        wb_exc;

  modport master (
    output req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
           req_rd, dm_readdata,
    input  req_ready, dm_memread, dm_memwrite, dm_address, dm_writedata,
           wb_valid, wb_rd, wb_data, wb_regwrite, wb_exc
  );

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
           req_rd, dm_readdata,
    output req_ready, dm_memread, dm_memwrite, dm_address, dm_writedata,
           wb_valid, wb_rd, wb_data, wb_regwrite, wb_exc
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit in front of a word-addressed data bank.
// Handles one request at a time; byte/half loads are extracted and extended, byte/half
// stores are done as read-modify-write since the bank only writes whole words.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_stage_lsu_if.slave (request handshake, bank strobes, MEM/WB result)
// Parameters:
//   WORD_ADDR_BITS : width of the word index driven to the bank
//   BIG_ENDIAN     : 1 = byte offset 0 is bits [31:24], 0 = bits [7:0]
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses raise wb_exc
// instead of being performed aligned down.
module mem_stage_lsu #(
  parameter int unsigned WORD_ADDR_BITS = 7,
  parameter bit          BIG_ENDIAN     = 1'b1
) (
  input logic             clk,
  input logic             reset,
  mem_stage_lsu_if.slave  bus
);

  localparam int unsigned AW = WORD_ADDR_BITS + 2;

  typedef enum logic [2:0] {StIdle, StLd, StWr, StRmwRd, StRmwWr, StResp} state_e;

  state_e          state_q, state_d;
  logic            load_q, exc_q, uns_q;
  logic [1:0]      size_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q, merged_q;
  logic [4:0]      rd_q;
  logic            wb_valid_q, wb_regwrite_q, wb_exc_q;
  logic [4:0]      wb_rd_q;
  logic [31:0]     wb_data_q;

  logic            misalign;
  logic [4:0]      byte_shift, half_shift, lane_shift;
  logic [31:0]     rd_shifted, load_ext, lane_mask, lane_ins, merged;
  logic            is_byte;
  logic            unused_addr;

  assign unused_addr = ^bus.req_addr[31:AW];

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane position within the word, from the latched address and endianness.
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_shift = {~addr_q[1:0], 3'b000};
      half_shift = {~addr_q[1], 4'b0000};
    end else begin
      byte_shift = {addr_q[1:0], 3'b000};
      half_shift = {addr_q[1], 4'b0000};
    end
    is_byte    = (size_q == 2'b00);
    lane_shift = is_byte ? byte_shift : half_shift;
    rd_shifted = bus.dm_readdata >> lane_shift;

    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, rd_shifted[7:0]}
                                : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, rd_shifted[15:0]}
                                : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = bus.dm_readdata;
    endcase

    lane_mask = (is_byte ? 32'h0000_00ff : 32'h0000_ffff) << lane_shift;
    lane_ins  = (is_byte ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]}) << lane_shift;
    merged    = (bus.dm_readdata & ~lane_mask) | lane_ins;
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.dm_memread   = 1'b0;
    bus.dm_memwrite  = 1'b0;
    bus.dm_writedata = 32'h0;
    bus.dm_address   = 32'h0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && (bus.req_load || bus.req_store)) begin
          if ((bus.req_load && bus.req_store) || misalign) state_d = StResp;
          else if (bus.req_load)                           state_d = StLd;
          else if (bus.req_size[1])                        state_d = StWr;
          else                                             state_d = StRmwRd;
        end
      end
      StLd: begin
        bus.dm_memread = 1'b1;
        bus.dm_address = 32'(addr_q[AW-1:2]);
        state_d        = StResp;
      end
      StWr: begin
        bus.dm_memwrite  = 1'b1;
        bus.dm_address   = 32'(addr_q[AW-1:2]);
        bus.dm_writedata = wdata_q;
        state_d          = StResp;
      end
      StRmwRd: begin
        bus.dm_memread = 1'b1;
        bus.dm_address = 32'(addr_q[AW-1:2]);
        state_d        = StRmwWr;
      end
      StRmwWr: begin
        bus.dm_memwrite  = 1'b1;
        bus.dm_address   = 32'(addr_q[AW-1:2]);
        bus.dm_writedata = merged_q;
        state_d          = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      load_q        <= 1'b0;
      exc_q         <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= 32'h0;
      rd_q          <= 5'h0;
      merged_q      <= 32'h0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_exc_q      <= 1'b0;
      wb_rd_q       <= 5'h0;
      wb_data_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      // Result flags are single-cycle pulses; rd/data hold.
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_exc_q      <= 1'b0;
      if ((state_q == StIdle) && bus.req_valid) begin
        load_q  <= bus.req_load;
        exc_q   <= (bus.req_load && bus.req_store) || misalign;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[AW-1:0];
        wdata_q <= bus.req_wdata;
        rd_q    <= bus.req_rd;
      end
      if (state_q == StLd)    wb_data_q <= load_ext;
      if (state_q == StRmwRd) merged_q  <= merged;
      if (state_q == StResp) begin
        wb_valid_q    <= 1'b1;
        wb_regwrite_q <= load_q && !exc_q;
        wb_exc_q      <= exc_q;
        wb_rd_q       <= rd_q;
      end
    end
  end

  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.wb_exc      = wb_exc_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic reset;
  logic bank_load;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(
    .WORD_ADDR_BITS (7),
    .BIG_ENDIAN     (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word-wide bank with combinational read.
  logic [31:0] bank [128];
  assign bus.dm_readdata = bank[bus.dm_address[6:0]];
  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 128; i++) bank[i] <= 32'(i * 10);
    end else if (bus.dm_memwrite) begin
      bank[bus.dm_address[6:0]] <= bus.dm_writedata;
    end
  end

  // Reference: byte-addressed big-endian memory image of the 512-byte bank.
  logic [7:0] ref_b [512];

  function automatic logic [31:0] ref_word(input int unsigned a);
    int unsigned w;
    w = a & ~32'd3;
    return {ref_b[w], ref_b[w+1], ref_b[w+2], ref_b[w+3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input string tag,
                         output logic [31:0] obs_data, output logic [31:0] obs_wword);
    int unsigned a, a2;
    logic        mis, exc, active, got;
    int          exp_lat, exp_rdc, exp_wrc, lat, rdc, wrc, rlow, ovl, n;
    logic [31:0] exp_data, exp_wword;
    logic [15:0] h;
    a = 32'(addr[8:0]);
`ifdef MISALIGN_TRAP_EN
    mis = ((sz == 2'b01) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    active    = ld || st;
    exc       = (ld && st) || (active && mis);
    exp_lat   = exc ? 1 : (ld ? 2 : (sz[1] ? 2 : 3));
    exp_rdc   = exc ? 0 : ((ld || !sz[1]) ? 1 : 0);
    exp_wrc   = (exc || !st) ? 0 : 1;
    exp_data  = 32'h0;
    exp_wword = 32'h0;
    if (ld && !exc) begin
      case (sz)
        2'b00: exp_data = uns ? {24'h0, ref_b[a]} : {{24{ref_b[a][7]}}, ref_b[a]};
        2'b01: begin
          a2 = a & ~32'd1;
          h  = {ref_b[a2], ref_b[a2+1]};
          exp_data = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: exp_data = ref_word(a);
      endcase
    end
    if (st && !exc) begin
      case (sz)
        2'b00: ref_b[a] = wdata[7:0];
        2'b01: begin
          a2 = a & ~32'd1;
          ref_b[a2]   = wdata[15:8];
          ref_b[a2+1] = wdata[7:0];
        end
        default: begin
          a2 = a & ~32'd3;
          {ref_b[a2], ref_b[a2+1], ref_b[a2+2], ref_b[a2+3]} = wdata;
        end
      endcase
      exp_wword = ref_word(a);
    end

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_load     = ld;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;

    got = 1'b0; lat = -1; rdc = 0; wrc = 0; rlow = 0; ovl = 0;
    obs_wword = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (bus.wb_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (bus.dm_memread) rdc++;
      if (bus.dm_memwrite) begin
        wrc++;
        obs_wword = bus.dm_writedata;
      end
      if (bus.dm_memread && bus.dm_memwrite) ovl++;
      if (!bus.req_ready) rlow++;
      @(negedge clk);
    end
    obs_data = bus.wb_data;

    if (!active) begin
      chk({tag, "_dropped_no_wb"}, 32'(got), 32'd0);
      chk({tag, "_dropped_no_strobe"}, 32'(rdc + wrc), 32'd0);
    end else begin
      chk({tag, "_wb_valid"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_rd_strobes"}, 32'(rdc), 32'(exp_rdc));
      chk({tag, "_wr_strobes"}, 32'(wrc), 32'(exp_wrc));
      chk({tag, "_overlap"}, 32'(ovl), 32'd0);
      chk({tag, "_ready_low"}, 32'(rlow), 32'(exp_lat));
      chk({tag, "_wb_exc"}, 32'(bus.wb_exc), 32'(exc));
      chk({tag, "_wb_regwrite"}, 32'(bus.wb_regwrite), 32'(ld && !exc));
      chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(rd));
      if (ld && !exc) chk({tag, "_wb_data"}, bus.wb_data, exp_data);
      if (st && !exc) chk({tag, "_wdata"}, obs_wword, exp_wword);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.wb_valid), 32'd0);
      chk({tag, "_data_hold"}, bus.wb_data, obs_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, w;
    logic        ld, st, u;
    logic [1:0]  sz;
    int          op, nv;
    logic [31:0] v;

    for (int i = 0; i < 128; i++) begin
      v = 32'(i * 10);
      {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]} = v;
    end
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'h0;
    reset = 1'b1;
    bank_load = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bank_load = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
    chk("rst_wb_exc", 32'(bus.wb_exc), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_strobes", 32'({bus.dm_memread, bus.dm_memwrite}), 32'd0);

    run_req(1, 0, 2'b10, 0, 32'h14, 32'h0, 5'd7, "lw14", d, w);
    chk("lw14_const", d, 32'h0000_0032);
    run_req(0, 1, 2'b10, 0, 32'h20, 32'h80FF_1234, 5'd1, "sw20", d, w);
    chk("sw20_const", w, 32'h80FF_1234);
    run_req(1, 0, 2'b00, 0, 32'h20, 32'h0, 5'd2, "lb20", d, w);
    chk("lb20_const", d, 32'hFFFF_FF80);
    run_req(1, 0, 2'b00, 1, 32'h20, 32'h0, 5'd3, "lbu20", d, w);
    chk("lbu20_const", d, 32'h0000_0080);
    run_req(1, 0, 2'b01, 0, 32'h22, 32'h0, 5'd4, "lh22", d, w);
    chk("lh22_const", d, 32'h0000_1234);
    run_req(1, 0, 2'b01, 1, 32'h20, 32'h0, 5'd5, "lhu20", d, w);
    chk("lhu20_const", d, 32'h0000_80FF);
    run_req(0, 1, 2'b00, 0, 32'h21, 32'h0000_00AB, 5'd6, "sb21", d, w);
    chk("sb21_const", w, 32'h80AB_1234);
    run_req(1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd8, "lw20", d, w);
    chk("lw20_const", d, 32'h80AB_1234);
    run_req(1, 0, 2'b10, 0, 32'h22, 32'h0, 5'd9, "lw22", d, w);
    run_req(1, 1, 2'b10, 0, 32'h30, 32'h1, 5'd10, "both", d, w);
    run_req(0, 0, 2'b10, 0, 32'h30, 32'h1, 5'd11, "neither", d, w);
    run_req(1, 0, 2'b10, 0, 32'h0000_0214, 32'h0, 5'd12, "lw_wrap", d, w);
    chk("lw_wrap_const", d, 32'h0000_0032);

    // Reset while RMW_WR strobes: the single write lands, no result follows.
    ref_b[32'h43] = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h43; bus.req_wdata = 32'h0000_005A; bus.req_rd = 5'd13;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstrmw_rd", 32'(bus.dm_memread), 32'd1);
    @(negedge clk);
    chk("rstrmw_wr", 32'(bus.dm_memwrite), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstrmw_ready", 32'(bus.req_ready), 32'd1);
    chk("rstrmw_wr_off", 32'(bus.dm_memwrite), 32'd0);
    chk("rstrmw_wb_data", bus.wb_data, 32'd0);
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.wb_valid) nv++;
      @(negedge clk);
    end
    chk("rstrmw_no_wb", 32'(nv), 32'd0);
    run_req(1, 0, 2'b10, 0, 32'h40, 32'h0, 5'd14, "lw40", d, w);
    chk("lw40_const", d, 32'h0000_005A);

    for (int t = 0; t < 60; t++) begin
      op = int'($urandom_range(0, 9));
      ld = (op <= 4) || (op == 8);
      st = (op >= 5 && op <= 8);
      if (op == 9) begin ld = 1'b0; st = 1'b0; end
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      run_req(ld, st, sz, u, $urandom, $urandom, 5'($urandom), $sformatf("rnd%0d", t), d, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
